// File: rtl/pool_if.sv
// pool_if: command, SRAM0 and status bundle between the pool controller and pool_engine
interface pool_if #(parameter int AW = 16);
    logic          cmd_valid;
    logic [15:0]   cmd_src_base;
    logic [15:0]   cmd_dst_base;
    logic [15:0]   cmd_C;
    logic [15:0]   cmd_H;
    logic [15:0]   cmd_W;
    logic [7:0]    cmd_kh;
    logic [7:0]    cmd_kw;
    logic [7:0]    cmd_sh;
    logic [7:0]    cmd_sw;
    logic          cmd_avg;
    logic [4:0]    cmd_avg_shift;
    logic          sram_rd_en;
    logic [AW-1:0] sram_rd_addr;
    logic [7:0]    sram_rd_data;
    logic          sram_wr_en;
    logic [AW-1:0] sram_wr_addr;
    logic [7:0]    sram_wr_data;
    logic          busy;
    logic          done;
    modport master (
        output cmd_valid, cmd_src_base, cmd_dst_base, cmd_C, cmd_H, cmd_W,
               cmd_kh, cmd_kw, cmd_sh, cmd_sw, cmd_avg, cmd_avg_shift, sram_rd_data,
        input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_src_base, cmd_dst_base, cmd_C, cmd_H, cmd_W,
               cmd_kh, cmd_kw, cmd_sh, cmd_sw, cmd_avg, cmd_avg_shift, sram_rd_data,
        output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, busy, done
    );
endinterface

// File: rtl/pool_engine.sv
// pool_engine: INT8 NCHW 2-D max pooling from SRAM0 back to SRAM0; AVGPOOL_EN adds average mode
module pool_engine #(
    parameter int SRAM0_AW = 16
) (
    input logic   clk,
    input logic   rst,
    pool_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, READ, WAIT, ACC, WRITE, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] src_q, dst_q, cn_q, h_q, w_q, c_q, iy_q, ix_q;
    logic [7:0] kh_q, kw_q, sh_q, sw_q, ky_q, kx_q, out;
    logic [SRAM0_AW-1:0] wr_ptr_q, rd_addr_q, wr_addr_q, rd_addr;
    logic [7:0] wr_data_q;
    logic rd_en_q, wr_en_q, busy_q, done_q;
    logic signed [23:0] acc_q, acc_d, acc_init, px;
    logic [31:0] nx, ny;
    logic bad, last_tap, last_col, last_row, last_ch;
`ifdef AVGPOOL_EN
    logic avg_q;
    logic [4:0] shift_q;
    logic signed [31:0] sum, shr;
`endif
    assign bus.sram_rd_en   = rd_en_q;
    assign bus.sram_rd_addr = rd_addr_q;
    assign bus.sram_wr_en   = wr_en_q;
    assign bus.sram_wr_addr = wr_addr_q;
    assign bus.sram_wr_data = wr_data_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    // window/loop bounds, tap address and accumulator update; output sizes come from these compares
    always_comb begin
        bad      = cn_q == 16'd0 || kh_q == 8'd0 || kw_q == 8'd0 || sh_q == 8'd0 || sw_q == 8'd0 ||
                   32'(kh_q) > 32'(h_q) || 32'(kw_q) > 32'(w_q);
        nx       = 32'(ix_q) + 32'(sw_q);
        ny       = 32'(iy_q) + 32'(sh_q);
        last_col = nx + 32'(kw_q) > 32'(w_q);
        last_row = ny + 32'(kh_q) > 32'(h_q);
        last_ch  = 32'(c_q) + 32'd1 == 32'(cn_q);
        last_tap = kx_q == kw_q - 8'd1 && ky_q == kh_q - 8'd1;
        rd_addr  = SRAM0_AW'(32'(src_q) + 32'(c_q) * 32'(h_q) * 32'(w_q) +
                   (32'(iy_q) + 32'(ky_q)) * 32'(w_q) + 32'(ix_q) + 32'(kx_q));
        px       = $signed({{16{bus.sram_rd_data[7]}}, bus.sram_rd_data});
`ifdef AVGPOOL_EN
        acc_init = avg_q ? 24'sd0 : -24'sd128;
        acc_d    = avg_q ? acc_q + px : (px > acc_q ? px : acc_q);
        sum      = 32'(acc_d) + $signed(shift_q == 5'd0 ? 32'd0 : 32'd1 << (shift_q - 5'd1));
        shr      = sum >>> shift_q;
        out      = !avg_q ? acc_d[7:0] : shr > 32'sd127 ? 8'h7f : shr < -32'sd128 ? 8'h80 : shr[7:0];
`else
        acc_init = -24'sd128;
        acc_d    = px > acc_q ? px : acc_q;
        out      = acc_d[7:0];
`endif
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // next-state: three cycles per tap, one write cycle per output pixel
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.cmd_valid ? INIT : IDLE;
            INIT:    state_d = bad ? DONE : READ;
            READ:    state_d = WAIT;
            WAIT:    state_d = ACC;
            ACC:     state_d = last_tap ? WRITE : READ;
            WRITE:   state_d = last_col && last_row && last_ch ? DONE : READ;
            default: state_d = IDLE;
        endcase
    end
    // datapath and registered outputs; write strobe is armed on the last tap so it lands in WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_en_q <= state_q == READ;
            wr_en_q <= state_q == ACC && last_tap;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    src_q <= bus.cmd_src_base;
                    dst_q <= bus.cmd_dst_base;
                    cn_q  <= bus.cmd_C;
                    h_q   <= bus.cmd_H;
                    w_q   <= bus.cmd_W;
                    kh_q  <= bus.cmd_kh;
                    kw_q  <= bus.cmd_kw;
                    sh_q  <= bus.cmd_sh;
                    sw_q  <= bus.cmd_sw;
`ifdef AVGPOOL_EN
                    avg_q   <= bus.cmd_avg;
                    shift_q <= bus.cmd_avg_shift;
`endif
                end
                INIT: begin
                    {c_q, iy_q, ix_q} <= '0;
                    {ky_q, kx_q}      <= '0;
                    acc_q             <= acc_init;
                    wr_ptr_q          <= SRAM0_AW'(dst_q);
                end
                READ: rd_addr_q <= rd_addr;
                ACC: begin
                    acc_q <= acc_d;
                    kx_q  <= kx_q == kw_q - 8'd1 ? 8'd0 : kx_q + 8'd1;
                    ky_q  <= last_tap ? 8'd0 : kx_q == kw_q - 8'd1 ? ky_q + 8'd1 : ky_q;
                    if (last_tap) begin
                        wr_data_q <= out;
                        wr_addr_q <= wr_ptr_q;
                    end
                end
                WRITE: begin
                    wr_ptr_q <= wr_ptr_q + SRAM0_AW'(1);
                    acc_q    <= acc_init;
                    ix_q     <= last_col ? 16'd0 : nx[15:0];
                    iy_q     <= !last_col ? iy_q : last_row ? 16'd0 : ny[15:0];
                    c_q      <= last_col && last_row ? c_q + 16'd1 : c_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed and random pooling jobs checked against a loop-level reference model
module tb_pool_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    pool_if #(.AW(16)) bus ();
    pool_engine #(.SRAM0_AW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [7:0]  mem [65536];
    int          errors = 0, checks = 0, overlap = 0;
    logic [15:0] wa_q[$], ra_q[$], ea_q[$];
    logic [7:0]  wd_q[$], ed_q[$];

    // SRAM0 model: one-cycle read latency, writes recorded as a stream
    always @(posedge clk) begin
        if (bus.sram_rd_en) begin
            bus.sram_rd_data <= mem[bus.sram_rd_addr];
            ra_q.push_back(bus.sram_rd_addr);
        end
        if (bus.sram_wr_en) begin
            wa_q.push_back(bus.sram_wr_addr);
            wd_q.push_back(bus.sram_wr_data);
        end
        if (bus.sram_rd_en && bus.sram_wr_en) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int src, dst, cn, h, w, kh, kw, sh, sw, avg, shift, output int npix);
        int m, v;
        ea_q.delete();
        ed_q.delete();
        npix = 0;
        if (cn == 0 || kh == 0 || kw == 0 || sh == 0 || sw == 0) return;
        for (int c = 0; c < cn; c++)
            for (int oy = 0; oy + kh <= h; oy += sh)
                for (int ox = 0; ox + kw <= w; ox += sw) begin
                    m = avg ? 0 : -128;
                    for (int ky = 0; ky < kh; ky++)
                        for (int kx = 0; kx < kw; kx++) begin
                            v = $signed(mem[16'(src + c * h * w + (oy + ky) * w + ox + kx)]);
                            m = avg ? m + v : (v > m ? v : m);
                        end
                    if (avg) begin
                        m = (m + (shift > 0 ? 1 << (shift - 1) : 0)) >>> shift;
                        m = m > 127 ? 127 : m < -128 ? -128 : m;
                    end
                    ea_q.push_back(16'(dst + npix));
                    ed_q.push_back(8'(m));
                    npix++;
                end
    endtask

    task automatic run_job(input string tag, input int src, dst, cn, h, w, kh, kw, sh, sw,
                           input int avg, shift, rp);
        int npix, cyc;
        logic seen;
        model(src, dst, cn, h, w, kh, kw, sh, sw, avg, shift, npix);
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        @(negedge clk);
        bus.cmd_src_base = 16'(src);
        bus.cmd_dst_base = 16'(dst);
        bus.cmd_C = 16'(cn);
        bus.cmd_H = 16'(h);
        bus.cmd_W = 16'(w);
        bus.cmd_kh = 8'(kh);
        bus.cmd_kw = 8'(kw);
        bus.cmd_sh = 8'(sh);
        bus.cmd_sw = 8'(sw);
        bus.cmd_avg = avg[0];
        bus.cmd_avg_shift = 5'(shift);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cyc = 1;
        seen = 1'b0;
        chk({tag, ".busy"}, bus.busy, 1);
        while (!seen && cyc < 20000) begin
            if (bus.done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
                bus.cmd_valid = cyc == rp;
                if (cyc == rp) begin
                    bus.cmd_src_base += 16'h0100;
                    bus.cmd_dst_base += 16'h0100;
                end
            end
        end
        chk({tag, ".done"}, seen, 1);
        chk({tag, ".cycles"}, cyc, 2 + npix * (3 * kh * kw + 1));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk({tag, ".idle"}, bus.busy, 0);
        chk({tag, ".done_1cyc"}, bus.done, 0);
        @(negedge clk);
        chk({tag, ".stay_idle"}, bus.busy, 0);
        chk({tag, ".nwrites"}, wa_q.size(), ea_q.size());
        for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            chk({tag, ".waddr"}, wa_q[i], ea_q[i]);
            chk({tag, ".wdata"}, wd_q[i], ed_q[i]);
        end
    endtask

    initial begin
        int src, dst, cn, h, w, kh, kw, avg, shift, found, bcnt, dcnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_src_base = '0;
        bus.cmd_dst_base = '0;
        {bus.cmd_C, bus.cmd_H, bus.cmd_W} = '0;
        {bus.cmd_kh, bus.cmd_kw, bus.cmd_sh, bus.cmd_sw} = '0;
        bus.cmd_avg = 1'b0;
        bus.cmd_avg_shift = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37);
        repeat (3) @(negedge clk);
        chk("rst.rd_en", bus.sram_rd_en, 0);
        chk("rst.rd_addr", bus.sram_rd_addr, 0);
        chk("rst.wr_en", bus.sram_wr_en, 0);
        chk("rst.wr_addr", bus.sram_wr_addr, 0);
        chk("rst.wr_data", bus.sram_wr_data, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 8'(i + 1);
        run_job("t1", 16'h0100, 16'h2000, 1, 4, 4, 2, 2, 2, 2, 0, 0, 0);
        chk("t1.p0", wd_q[0], 8'd6);
        chk("t1.p1", wd_q[1], 8'd8);
        chk("t1.p2", wd_q[2], 8'd14);
        chk("t1.p3", wd_q[3], 8'd16);

        for (int i = 0; i < 9; i++) mem[16'h0300 + i] = i == 4 ? 8'd7 : 8'hfb;
        run_job("t2", 16'h0300, 16'h2100, 1, 3, 3, 2, 2, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) chk("t2.centre", wd_q[i], 8'd7);

        {mem[16'h0400], mem[16'h0401], mem[16'h0402], mem[16'h0403]} = {8'h80, 8'h9c, 8'ha6, 8'hfd};
        {mem[16'h0404], mem[16'h0405], mem[16'h0406], mem[16'h0407]} = {8'hff, 8'hfe, 8'hfd, 8'hfc};
        run_job("t3", 16'h0400, 16'h2200, 2, 2, 2, 2, 2, 2, 2, 0, 0, 0);
        chk("t3.ch0", wd_q[0], 8'hfd);
        chk("t3.ch1", wd_q[1], 8'hff);
        for (int a = 16'h0404; a <= 16'h0407; a++) begin
            found = 0;
            foreach (ra_q[i]) if (ra_q[i] == 16'(a)) found = 1;
            chk("t3.rd_cover", found, 1);
        end

        run_job("t4_bad_kh", 16'h0100, 16'h2300, 1, 4, 4, 5, 2, 1, 1, 0, 0, 2);
        run_job("t5_repulse", 16'h0100, 16'h2400, 1, 4, 4, 2, 2, 2, 2, 0, 0, 5);
        chk("t5.p3", wd_q[3], 8'd16);
        chk("t5.dst", wa_q[0], 16'h2400);

        for (int n = 0; n < 12; n++) begin
            cn = $urandom_range(1, 3);
            h = $urandom_range(1, 8);
            w = $urandom_range(1, 8);
            kh = $urandom_range(1, 4);
            kw = $urandom_range(1, 4);
            src = $urandom_range(0, 16'h3000);
            dst = 16'h8000 + n * 16'h0100;
            avg = 0;
            shift = 0;
`ifdef AVGPOOL_EN
            avg = $urandom_range(0, 1);
            shift = $urandom_range(0, 6);
`endif
            for (int i = 0; i < cn * h * w; i++) mem[src + i] = 8'($urandom);
            run_job("rand", src, dst, cn, h, w, kh, kw, $urandom_range(1, 3), $urandom_range(1, 3),
                    avg, shift, 0);
        end

`ifdef AVGPOOL_EN
        {mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]} = {8'd10, 8'd11, 8'd12, 8'd13};
        run_job("t6_avg", 16'h0500, 16'h2500, 1, 2, 2, 2, 2, 2, 2, 1, 2, 0);
        chk("t6.avg", wd_q[0], 8'd12);
        for (int i = 0; i < 4; i++) mem[16'h0600 + i] = 8'd127;
        run_job("t6_sat", 16'h0600, 16'h2600, 1, 2, 2, 2, 2, 2, 2, 1, 0, 0);
        chk("t6.sat", wd_q[0], 8'd127);
`endif

        @(negedge clk);
        bus.cmd_src_base = 16'h0100;
        bus.cmd_dst_base = 16'h2700;
        {bus.cmd_C, bus.cmd_H, bus.cmd_W} = {16'd1, 16'd4, 16'd4};
        {bus.cmd_kh, bus.cmd_kw, bus.cmd_sh, bus.cmd_sw} = {8'd2, 8'd2, 8'd2, 8'd2};
        bus.cmd_avg = 1'b0;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bcnt = 1;
        for (int i = 0; i < 200 && bcnt < 10; i++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
        end
        chk("rst_mid.reached", bcnt, 10);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.rd_en", bus.sram_rd_en, 0);
        chk("rst_mid.rd_addr", bus.sram_rd_addr, 0);
        chk("rst_mid.wr_en", bus.sram_wr_en, 0);
        chk("rst_mid.wr_addr", bus.sram_wr_addr, 0);
        chk("rst_mid.wr_data", bus.sram_wr_data, 0);
        chk("rst_mid.busy", bus.busy, 0);
        chk("rst_mid.done", bus.done, 0);
        rst = 1'b0;
        wa_q.delete();
        dcnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("rst_mid.no_done", dcnt, 0);
        chk("rst_mid.no_writes", wa_q.size(), 0);
        chk("rd_wr_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
